// File: rtl/fetch_unit.sv
// VLIW instruction fetch: PC, memory fetch port, bundle FIFO with valid/ready to decode.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    output logic [31:0]  mem_pc_out,
    input  logic [127:0] mem_bundle_in,
    input  logic         halt_in,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         bundle_valid,
    input  logic         bundle_ready,
    output logic [127:0] bundle_data,
    output logic [31:0]  bundle_pc,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_stall
);
    localparam int          PW     = $clog2(FIFO_DEPTH);
    localparam int          CW     = PW + 1;
    localparam logic [31:0] RST_PC = {RESET_PC[31:4], 4'b0};

    typedef struct packed {
        logic [31:0]  pc;
        logic [127:0] bundle;
    } entry_t;

    entry_t          fifo [FIFO_DEPTH];
    logic [31:0]     pc;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            full, pop, can_enq, enq;

    assign full         = (count == CW'(FIFO_DEPTH));
    assign bundle_valid = (count != '0);
    assign pop          = bundle_valid & bundle_ready;
    assign can_enq      = !halt_in & (!full | pop);
    // Redirect squashes the bundle fetched at the old pc.
    assign enq          = can_enq & !redirect_valid;
    assign mem_pc_out   = pc;

    assign bundle_data  = bundle_valid ? fifo[rd_ptr].bundle : '0;
    assign bundle_pc    = bundle_valid ? fifo[rd_ptr].pc     : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RST_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            pc     <= {redirect_pc[31:4], 4'b0};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                pc     <= pc + 32'd16;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (enq && !pop)
                count <= count + 1'b1;
            else if (!enq && pop)
                count <= count - 1'b1;
        end
    end

    // Storage needs no reset: head outputs are masked by bundle_valid.
    always_ff @(posedge clk) begin
        if (enq)
            fifo[wr_ptr] <= '{pc: pc, bundle: mem_bundle_in};
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall;
    assign stall = !halt_in & !redirect_valid & full & !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (enq && perf_fetched != '1)
                perf_fetched <= perf_fetched + 32'd1;
            if (stall && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`else
    assign perf_fetched = '0;
    assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: reference queue of expected {pc, bundle} entries.
module tb_fetch_unit;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  mem_pc_out;
    logic [127:0] mem_bundle_in;
    logic         halt_in = 1'b1;
    logic         redirect_valid = 1'b0;
    logic [31:0]  redirect_pc = '0;
    logic         bundle_valid;
    logic         bundle_ready = 1'b0;
    logic [127:0] bundle_data;
    logic [31:0]  bundle_pc;
    logic [31:0]  perf_fetched, perf_stall;

    fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .mem_pc_out(mem_pc_out), .mem_bundle_in(mem_bundle_in),
        .halt_in(halt_in), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .bundle_valid(bundle_valid), .bundle_ready(bundle_ready), .bundle_data(bundle_data),
        .bundle_pc(bundle_pc), .perf_fetched(perf_fetched), .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    // Memory word at byte address a holds a/4 + 1, so words 0..7 read 1..8.
    function automatic logic [31:0] word(input logic [31:0] a);
        return (a >> 2) + 32'd1;
    endfunction

    function automatic logic [127:0] bundle_of(input logic [31:0] a);
        return {word(a), word(a + 32'd4), word(a + 32'd8), word(a + 32'd12)};
    endfunction

    assign mem_bundle_in = bundle_of(mem_pc_out);

    typedef struct packed {
        logic [31:0]  pc;
        logic [127:0] b;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc = '0;
    int          m_fetched = 0;
    int          m_stall = 0;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_perf();
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, m_fetched);
        check("perf_stall", perf_stall, m_stall);
`else
        check("perf_fetched", perf_fetched, 0);
        check("perf_stall", perf_stall, 0);
`endif
    endtask

    // One cycle: drive inputs, compare outputs, then advance the reference to the next edge.
    task automatic step(input logic h, input logic rv, input logic [31:0] rp, input logic rdy);
        int  sz;
        logic pp;
        @(negedge clk);
        halt_in = h; redirect_valid = rv; redirect_pc = rp; bundle_ready = rdy;
        #1;
        sz = q.size();
        pp = rdy && sz != 0;
        check("valid", bundle_valid, sz != 0);
        check("mem_pc", mem_pc_out, m_pc);
        if (sz != 0) begin
            check("head_pc", bundle_pc, q[0].pc);
            check("head_data", bundle_data, q[0].b);
        end else begin
            check("idle_pc", bundle_pc, 0);
            check("idle_data", bundle_data, 0);
        end
        check_perf();
        if (!h && !rv && sz == DEPTH && !pp) m_stall++;
        if (pp) void'(q.pop_front());
        if (rv) begin
            q.delete();
            m_pc = {rp[31:4], 4'b0};
        end else if (!h && (sz < DEPTH || pp)) begin
            q.push_back(ent_t'{m_pc, bundle_of(m_pc)});
            m_fetched++;
            m_pc = m_pc + 32'd16;
        end
    endtask

    initial begin
        #12;
        check("rst_valid", bundle_valid, 0);
        check("rst_data", bundle_data, 0);
        check("rst_pc", bundle_pc, 0);
        check("rst_mem_pc", mem_pc_out, 0);
        check_perf();

        // Release with fetch enabled: first bundle valid after the first edge.
        @(negedge clk);
        rst = 1'b0; halt_in = 1'b0; bundle_ready = 1'b1;
        #1;
        q.push_back(ent_t'{m_pc, bundle_of(m_pc)});
        m_fetched++;
        m_pc = m_pc + 32'd16;
        step(0, 0, 0, 1);
        check("first_bundle", bundle_data, 128'h00000001_00000002_00000003_00000004);
        step(0, 0, 0, 1);
        check("second_pc", bundle_pc, 32'd16);

        // Back to pc 0 and back-pressure until the FIFO is full.
        step(0, 1, 32'h0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        check("full_mem_pc", mem_pc_out, 32'd64);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

        // Redirect with entries queued; low nibble of target ignored.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 32'h0000_004C, 0);
        step(0, 0, 0, 1);
        check("redir_mem_pc", mem_pc_out, 32'h40);
        step(0, 0, 0, 1);
        check("redir_head", bundle_pc, 32'h40);

        // Halt drains the FIFO while pc holds, then resumes.
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
        check("halt_drained", bundle_valid, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        // Redirect during halt, then pc wrap at the top of memory.
        step(1, 1, 32'h0000_1234, 1);
        step(1, 0, 0, 1);
        step(0, 1, 32'hFFFF_FFF7, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        check("wrap_pc", bundle_pc, 32'h0);

        for (int i = 0; i < 60; i++)
            step($urandom_range(3) == 0, $urandom_range(7) == 0, $urandom, $urandom_range(3) != 0);

        // Fill, then asynchronous reset mid-cycle.
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        @(negedge clk);
        #2;
        halt_in = 1'b1;
        rst = 1'b1;
        #1;
        check("arst_valid", bundle_valid, 0);
        check("arst_mem_pc", mem_pc_out, 0);
        check("arst_data", bundle_data, 0);
        check("arst_perf_f", perf_fetched, 0);
        check("arst_perf_s", perf_stall, 0);
        q.delete();
        m_pc = '0; m_fetched = 0; m_stall = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step(0, 0, 0, $urandom_range(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the VLIW core. Holds the program counter, drives the main memory instruction port, and captures the 128-bit four-slot bundle returned each cycle. Bundles are buffered in a small FIFO and handed to decode over a valid/ready handshake. Supports redirect (branch/jump) with flush and an external halt.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [3:0] are forced to 0.
- FIFO_DEPTH, 4: number of bundle FIFO entries. Must be a power of two and at least 2.

- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- mem_pc_out  output  32  fetch address to main memory instruction port
- mem_bundle_in  input  128  bundle from memory for mem_pc_out (combinational); slot0 = [127:96] at PC, slot3 = [31:0] at PC+12
- halt_in  input  1  when high, no new fetch is enqueued and PC holds
- redirect_valid  input  1  redirect request from execute/branch unit
- redirect_pc  input  32  redirect target; bits [3:0] are ignored (treated as 0)
- bundle_valid  output  1  FIFO head valid to decode
- bundle_ready  input  1  decode accepts head this cycle
- bundle_data  output  128  FIFO head bundle; 0 when bundle_valid=0
- bundle_pc  output  32  PC of FIFO head bundle; 0 when bundle_valid=0
- perf_fetched  output  32  bundles enqueued (FETCH_PERF_CNT_EN)
- perf_stall  output  32  cycles in which fetch was blocked by a full FIFO (FETCH_PERF_CNT_EN)

## Operation
- State: pc register, FIFO (entries of {pc, bundle}), read/write pointers, count in the range 0..FIFO_DEPTH.
- mem_pc_out = pc at all times; pc is always 16-byte aligned.
- pop = bundle_valid & bundle_ready.
- can_enq = !halt_in & (count < FIFO_DEPTH | pop). A full FIFO can accept a fetch in the same cycle as a pop.
- Normal cycle with can_enq: write {pc, mem_bundle_in} at the write pointer; pc <= pc + 16.
- pc wraps modulo 2^32 (32'hFFFF_FFF0 + 16 = 0).
- Redirect has priority over everything else:
  - count <= 0 and pointers reset, flushing the FIFO.
  - pc <= {redirect_pc[31:4], 4'b0}.
  - No enqueue that cycle; the bundle fetched at the old pc is discarded.
  - A pop in the same cycle is a completed transfer to decode.
- halt_in without redirect: pc and the enqueue path freeze. Pops continue, so the FIFO drains.
- redirect_valid while halt_in is high: pc is still updated and the FIFO flushed. Fetch resumes at the target once halt_in drops.
- No enqueue and no pop: count is unchanged. Simultaneous enqueue and pop: count is unchanged and both pointers advance.

## Timing
- Reset values:
  - pc = RESET_PC & ~32'hF, count = 0, bundle_valid = 0, bundle_data = 0, bundle_pc = 0.
  - perf_fetched = 0, perf_stall = 0.
- Reset is asynchronous. Asserting rst mid-operation clears all state immediately.
- Fetch latency: the bundle at pc in cycle N appears at the FIFO head (if the FIFO was empty) with bundle_valid=1 in cycle N+1.
- First bundle after reset release: bundle_valid=1 after the first rising edge with rst low.
- Redirect asserted in cycle N:
  - bundle_valid=0 in cycle N+1, with mem_pc_out = target.
  - Target bundle is valid in cycle N+2.
- Sustained throughput: one bundle per cycle while bundle_ready=1 and halt_in=0.
- bundle_valid depends only on registered state (count != 0), never on bundle_ready.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - perf_fetched increments on each enqueue.
  - perf_stall increments on each cycle with !halt_in & !redirect_valid & count==FIFO_DEPTH & !pop.
  - Both counters saturate at 32'hFFFF_FFFF and are cleared by rst only.
- FETCH_PERF_CNT_EN undefined: no counter logic; perf_fetched and perf_stall are tied to 0.

## Test plan
- Reset release with RESET_PC=0, memory words 0..7 = 1..8, bundle_ready=1 -> cycle 1 bundle_pc=0, bundle_data=128'h00000001_00000002_00000003_00000004; cycle 2 bundle_pc=16, data {5,6,7,8}.
- bundle_ready=0 for 10 cycles -> count saturates at 4 with bundle_pc=0 held; mem_pc_out stops at 64; perf_stall=6 (enabled). Then ready=1 -> bundles at pc 0,16,32,48,64 follow in consecutive cycles with no bubble.
- redirect_valid=1 with redirect_pc=32'h0000_004C while the FIFO holds 3 entries -> next cycle bundle_valid=0 and mem_pc_out=32'h40; the following cycle bundle_pc=32'h40.
- halt_in=1 with 2 entries and ready=1 -> two pops, then bundle_valid=0; mem_pc_out is constant. Release halt -> fetch resumes at the held pc.
- pc=32'hFFFF_FFF0, no stall -> next enqueued bundle_pc=0.
- rst asserted mid-stream with a full FIFO -> bundle_valid=0 immediately (before the next clock edge), mem_pc_out=RESET_PC, and perf counters=0.
